// File: rtl/sum_window_accumulator.sv
// Windowed saturating accumulator: sums WINDOW accepted samples and presents
// the total plus a saturation flag on a valid/ready result handshake.
module sum_window_accumulator #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 16,
    parameter int unsigned WINDOW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clear,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned SUM_W = ACC_W + 1;

    typedef enum logic [0:0] {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_sat;
    logic               w_sat_nxt;
    logic [ACC_W-1:0]   r_out_data;
    logic [ACC_W-1:0]   w_out_data_nxt;
    logic               r_out_sat;
    logic               w_out_sat_nxt;
    logic               r_out_valid;
    logic               w_out_valid_nxt;

    logic               w_accept;
    logic               w_last;
    logic [SUM_W-1:0]   w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_acc_add;
    logic               w_sat_add;

    assign in_ready  = (r_state == ST_ACCUM) && !clear && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CNT_W'(WINDOW - 1));

    // One-bit-wider add so overflow past 2^ACC_W-1 is visible as the carry.
    assign w_sum     = {1'b0, r_acc} + SUM_W'(in_data);
    assign w_ovf     = w_sum[ACC_W];
    assign w_acc_add = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
    assign w_sat_add = r_sat | w_ovf;

    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_valid = r_out_valid;

    // Next-state and result logic; clear overrides everything except rst.
    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_sat_nxt       = r_sat;
        w_out_data_nxt  = r_out_data;
        w_out_sat_nxt   = r_out_sat;
        w_out_valid_nxt = r_out_valid;

        if (clear) begin
            w_state_nxt     = ST_ACCUM;
            w_acc_nxt       = '0;
            w_cnt_nxt       = '0;
            w_sat_nxt       = 1'b0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_ACCUM: begin
                    w_out_valid_nxt = 1'b0;
                    if (w_accept) begin
                        w_acc_nxt = w_acc_add;
                        w_sat_nxt = w_sat_add;
                        if (w_last) begin
                            w_cnt_nxt       = '0;
                            w_out_data_nxt  = w_acc_add;
                            w_out_sat_nxt   = w_sat_add;
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = ST_HOLD;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_state_nxt     = ST_ACCUM;
                        w_acc_nxt       = '0;
                        w_cnt_nxt       = '0;
                        w_sat_nxt       = 1'b0;
                        w_out_valid_nxt = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = ST_ACCUM;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_sat       <= w_sat_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_sat   <= w_out_sat_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule
